// File: rtl/alu_arbiter_if.sv
// Bundles the request, ALU and response signals of the two-requester ALU arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters'/ALU view.
interface alu_arbiter_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 3
);
   logic              req0_valid;
   logic              req0_ready;
   logic [CTRL_W-1:0] req0_ctrl;
   logic [WIDTH-1:0]  req0_a;
   logic [WIDTH-1:0]  req0_b;

   logic              req1_valid;
   logic              req1_ready;
   logic [CTRL_W-1:0] req1_ctrl;
   logic [WIDTH-1:0]  req1_a;
   logic [WIDTH-1:0]  req1_b;

   logic [WIDTH-1:0]  alu_rs1;
   logic [WIDTH-1:0]  alu_rs2;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [WIDTH-1:0]  alu_rd;
   logic              alu_z;

   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [WIDTH-1:0]  rsp_rd;
   logic              rsp_z;
   logic              busy;

   modport slave (
      input  req0_valid, req0_ctrl, req0_a, req0_b,
      input  req1_valid, req1_ctrl, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_rs1, alu_rs2, alu_ctrl,
      input  alu_rd, alu_z,
      output rsp0_valid, rsp1_valid, rsp_rd, rsp_z, busy,
      input  rsp0_ready, rsp1_ready
   );

   modport master (
      output req0_valid, req0_ctrl, req0_a, req0_b,
      output req1_valid, req1_ctrl, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_rs1, alu_rs2, alu_ctrl,
      output alu_rd, alu_z,
      input  rsp0_valid, rsp1_valid, rsp_rd, rsp_z, busy,
      output rsp0_ready, rsp1_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; one operation in flight.
// Result is sampled ALU_LAT edges after the accept edge and held until the owner's rsp_ready.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int CTRL_W  = 3,
   parameter int ALU_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);
   localparam int              CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [WIDTH-1:0]  a;
      logic [WIDTH-1:0]  b;
   } op_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             owner;
   op_t              op_q;
   logic [WIDTH-1:0] rd_q;
   logic             z_q;
   logic             rsp0_v;
   logic             rsp1_v;
   logic             busy_q;
   logic             grant0;
   logic             grant1;
   logic             owner_rdy;

   // On a tie the requester that did not win last time gets the ALU.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state == IDLE) begin
         grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
         grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
      end
   end

   assign owner_rdy = owner ? bus.rsp1_ready : bus.rsp0_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_q       <= '0;
         rd_q       <= '0;
         z_q        <= 1'b0;
         rsp0_v     <= 1'b0;
         rsp1_v     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_q       <= grant1 ? op_t'{bus.req1_ctrl, bus.req1_a, bus.req1_b}
                                       : op_t'{bus.req0_ctrl, bus.req0_a, bus.req0_b};
                  owner      <= grant1;
                  last_grant <= grant1;
                  cnt        <= CNT_LOAD;
                  busy_q     <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rd_q   <= bus.alu_rd;
                  z_q    <= bus.alu_z;
                  rsp0_v <= !owner;
                  rsp1_v <= owner;
                  state  <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (owner_rdy) begin
                  rsp0_v <= 1'b0;
                  rsp1_v <= 1'b0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.alu_ctrl   = op_q.ctrl;
   assign bus.alu_rs1    = op_q.a;
   assign bus.alu_rs2    = op_q.b;
   assign bus.rsp0_valid = rsp0_v;
   assign bus.rsp1_valid = rsp1_v;
   assign bus.rsp_rd     = rd_q;
   assign bus.rsp_z      = z_q;
   assign bus.busy       = busy_q;
endmodule
